issue_unit: RTL and testbench
=============================

# issue_unit

Back-end issue unit for the out-of-order core: drains the four execution queues filled by dispatch (integer, load/store, multiply, divide), choosing at most one head entry per cycle. It reserves the common data bus (CDB) slot in which that instruction's result will appear, so no two units ever drive the CDB in the same cycle. It also tracks the non-pipelined divider. Its read strobes are the queue `rd_en` inputs, and its CDB-owner output steers the CDB mux.

## Interface
Parameters:
- INT_LAT, 1, cycles from issue to CDB for integer ops
- LD_ST_LAT, 2, cycles from issue to CDB for load/store
- MULT_LAT, 4, cycles from issue to CDB for multiply (fully pipelined)
- DIV_LAT, 7, cycles from issue to CDB for divide (non-pipelined). Must be ≥ every other latency. Every latency ≥ 1.

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_int_ready  in  1  integer queue non-empty and head operands valid
- i_ld_st_ready  in  1  load/store queue non-empty and head operands valid
- i_mult_ready  in  1  multiply queue non-empty and head operands valid
- i_div_ready  in  1  divide queue non-empty and head operands valid
- i_flush  in  1  branch-taken flush (cdb_branch_taken); blocks issue this cycle
- o_int_rd  out  1  pop/issue integer head (combinational)
- o_ld_st_rd  out  1  pop/issue load/store head (combinational)
- o_mult_rd  out  1  pop/issue multiply head (combinational)
- o_div_rd  out  1  pop/issue divide head (combinational)
- o_cdb_valid  out  1  a unit owns the CDB this cycle (registered)
- o_cdb_owner  out  2  owner: 00 int, 01 ld_st, 10 mult, 11 div (registered)
- o_div_busy  out  1  divider occupied (registered)

## Operation
- Reservation register: slots slot[1..DIV_LAT]. Each slot holds a valid bit and a 2-bit owner. {o_cdb_valid, o_cdb_owner} = slot[1].
- Every clock (not in reset):
  - slot[k] ← slot[k+1] for k < DIV_LAT.
  - slot[DIV_LAT] ← empty.
  - If a unit with latency L issues, slot[L] ← {1, owner}. This write overrides the shifted value, which is guaranteed empty.
- Eligibility of a unit with latency L requires all of the following:
  - its ready input = 1
  - i_flush = 0
  - slot[L+1] empty; slot[DIV_LAT+1] is treated as always empty
  - for divide only: divider counter = 0
- Priority among eligible units is fixed: div > mult > ld_st > int. Exactly the highest eligible unit gets its rd strobe; the others are 0.
  - Rd outputs are one-hot or all-zero.
  - Starvation of lower priorities is permitted.
- Divider counter: on div issue it loads DIV_LAT−1, otherwise it decrements while non-zero. o_div_busy = (counter ≠ 0).
- Flush suppresses only new issue. Existing reservations and the divider counter keep running, because in-flight results still complete on the CDB.
- Simultaneous events:
  - Issue and shift happen on the same edge.
  - Slot[1] leaving and a new L=1 reservation landing in slot[1] on the same edge is legal.
- Reset (i_rst high at an edge):
  - all slots empty, counter 0
  - o_cdb_valid 0, o_cdb_owner 00, o_div_busy 0
  - all rd outputs held 0 while i_rst is high
- Reset mid-operation discards all reservations. Queues are reset by the same signal.

## Timing
- Issue at cycle t means the rd strobe is high during t and the queue pops at edge t+1.
- Result owner appears on o_cdb_valid/o_cdb_owner at cycle t+L.
- Back-to-back divides issue at t and t+DIV_LAT. o_div_busy is high in cycles t+1 … t+DIV_LAT−1.
- A mult can issue every cycle as long as its slots are free.
- No combinational path from i_*_ready to o_cdb_*. The rd outputs are combinational from ready, flush, slot state and the counter.
- At most one CDB owner per cycle, guaranteed by construction. The bench asserts this every cycle.

## Test plan
- Reset: i_rst high for 2 cycles with all readies = 1 → all rd outputs 0, o_cdb_valid 0. In the first cycle after release, o_div_rd = 1 and the other rd outputs are 0.
- Single integer: only i_int_ready = 1 at cycle 10 → o_int_rd = 1 at 10; o_cdb_valid = 1, owner 00 at 11, then 0 at 12.
- Slot conflict:
  - mult issues at t.
  - i_ld_st_ready = 1 from t+2 → o_ld_st_rd = 0 at t+2 and 1 at t+3.
  - CDB owners: 10 at t+4, 01 at t+5.
- Divider occupancy: i_div_ready held 1 → issues at t, t+7, t+14. o_div_busy = 1 over t+1..t+6. CDB owner 11 at t+7 and t+14.
- Priority/ordering: all four ready from t, slots empty → issue order div t, mult t+1, ld_st t+2, int t+5. CDB owners: 01 at t+4, 10 at t+5, 00 at t+6, 11 at t+7.
- Flush: mult issues at t; i_flush = 1 at t+1 with i_int_ready = 1 → o_int_rd = 0 at t+1. Mult still on CDB at t+4. int issues at t+2 → CDB at t+3.

Source files
------------

// File: rtl/issue_unit.sv
// Issue unit: picks at most one ready queue head per cycle (div > mult > ld_st > int)
// and reserves the CDB slot in which its result will appear; tracks the non-pipelined divider.
module issue_unit #(
  parameter int INT_LAT   = 1,
  parameter int LD_ST_LAT = 2,
  parameter int MULT_LAT  = 4,
  parameter int DIV_LAT   = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_int_ready,
  input  logic       i_ld_st_ready,
  input  logic       i_mult_ready,
  input  logic       i_div_ready,
  input  logic       i_flush,
  output logic       o_int_rd,
  output logic       o_ld_st_rd,
  output logic       o_mult_rd,
  output logic       o_div_rd,
  output logic       o_cdb_valid,
  output logic [1:0] o_cdb_owner,
  output logic       o_div_busy
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  localparam logic [1:0] OWN_INT   = 2'b00;
  localparam logic [1:0] OWN_LD_ST = 2'b01;
  localparam logic [1:0] OWN_MULT  = 2'b10;
  localparam logic [1:0] OWN_DIV   = 2'b11;

  logic [DIV_LAT:1]      slot_vld_q, slot_vld_d;
  logic [DIV_LAT:1][1:0] slot_own_q, slot_own_d;
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;

  // Extra always-empty top slot so slot[L+1] is a legal index for every unit.
  logic [DIV_LAT+1:1] vld_ext;
  logic               issue_ok;
  logic               int_elig, ld_st_elig, mult_elig, div_elig;

  assign vld_ext  = {1'b0, slot_vld_q};
  assign issue_ok = ~i_rst & ~i_flush;

  always_comb begin
    int_elig   = i_int_ready   & issue_ok & ~vld_ext[INT_LAT+1];
    ld_st_elig = i_ld_st_ready & issue_ok & ~vld_ext[LD_ST_LAT+1];
    mult_elig  = i_mult_ready  & issue_ok & ~vld_ext[MULT_LAT+1];
    div_elig   = i_div_ready   & issue_ok & ~vld_ext[DIV_LAT+1] & (div_cnt_q == '0);

    o_div_rd   = div_elig;
    o_mult_rd  = mult_elig  & ~div_elig;
    o_ld_st_rd = ld_st_elig & ~div_elig & ~mult_elig;
    o_int_rd   = int_elig   & ~div_elig & ~mult_elig & ~ld_st_elig;
  end

  always_comb begin
    slot_vld_d = '0;
    slot_own_d = '0;
    for (int k = 1; k < DIV_LAT; k++) begin
      slot_vld_d[k] = slot_vld_q[k+1];
      slot_own_d[k] = slot_own_q[k+1];
    end

    // The target slot is known empty after the shift, so the write simply lands.
    if (o_int_rd) begin
      slot_vld_d[INT_LAT] = 1'b1;
      slot_own_d[INT_LAT] = OWN_INT;
    end
    if (o_ld_st_rd) begin
      slot_vld_d[LD_ST_LAT] = 1'b1;
      slot_own_d[LD_ST_LAT] = OWN_LD_ST;
    end
    if (o_mult_rd) begin
      slot_vld_d[MULT_LAT] = 1'b1;
      slot_own_d[MULT_LAT] = OWN_MULT;
    end
    if (o_div_rd) begin
      slot_vld_d[DIV_LAT] = 1'b1;
      slot_own_d[DIV_LAT] = OWN_DIV;
    end

    if (o_div_rd) begin
      div_cnt_d = CNT_W'(DIV_LAT - 1);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_vld_q <= '0;
      slot_own_q <= '0;
      div_cnt_q  <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_own_q <= slot_own_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  assign o_cdb_valid = slot_vld_q[1];
  assign o_cdb_owner = slot_own_q[1];
  assign o_div_busy  = (div_cnt_q != '0);

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: each scenario task drives inputs just after the rising
// edge and checks strobes and CDB outputs at the falling edge against hand-derived values.
module tb_issue_unit;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_int_ready, i_ld_st_ready, i_mult_ready, i_div_ready, i_flush;
  logic       o_int_rd, o_ld_st_rd, o_mult_rd, o_div_rd;
  logic       o_cdb_valid;
  logic [1:0] o_cdb_owner;
  logic       o_div_busy;

  int errors = 0;
  int checks = 0;

  issue_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_int_ready   (i_int_ready),
    .i_ld_st_ready (i_ld_st_ready),
    .i_mult_ready  (i_mult_ready),
    .i_div_ready   (i_div_ready),
    .i_flush       (i_flush),
    .o_int_rd      (o_int_rd),
    .o_ld_st_rd    (o_ld_st_rd),
    .o_mult_rd     (o_mult_rd),
    .o_div_rd      (o_div_rd),
    .o_cdb_valid   (o_cdb_valid),
    .o_cdb_owner   (o_cdb_owner),
    .o_div_busy    (o_div_busy)
  );

  always #5 i_clk = ~i_clk;

  // Strobe vector order used throughout: {div, mult, ld_st, int}
  function automatic logic [3:0] rd_vec();
    return {o_div_rd, o_mult_rd, o_ld_st_rd, o_int_rd};
  endfunction

  always @(negedge i_clk) begin
    if (i_rst === 1'b0) begin
      checks++;
      if ($countones(rd_vec()) > 1) begin
        errors++;
        $display("FAIL onehot_rd: rd=%b required at most one bit set", rd_vec());
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ready(input logic [3:0] r);
    {i_div_ready, i_mult_ready, i_ld_st_ready, i_int_ready} = r;
  endtask

  task automatic do_reset();
    next_cycle();
    i_rst = 1'b1;
    set_ready(4'b0000);
    i_flush = 1'b0;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    i_rst   = 1'b1;
    i_flush = 1'b0;
    set_ready(4'b1111);
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      checks++;
      if (rd_vec() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_rd c=%0d: rd=%b required 0000", c, rd_vec());
      end
      if (c == 1) begin
        checks++;
        if ({o_cdb_valid, o_cdb_owner, o_div_busy} !== 4'b0000) begin
          errors++;
          $display("FAIL reset_regs: valid/owner/busy=%b required 0000",
                   {o_cdb_valid, o_cdb_owner, o_div_busy});
        end
      end
      next_cycle();
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (rd_vec() !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release_rd: rd=%b required 1000", rd_vec());
    end
    do_reset();
  endtask

  task automatic test_single_int();
    set_ready(4'b0001);
    @(negedge i_clk);
    checks++;
    if (rd_vec() !== 4'b0001 || o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_int_issue: rd=%b valid=%b required rd=0001 valid=0", rd_vec(), o_cdb_valid);
    end
    next_cycle();
    set_ready(4'b0000);
    @(negedge i_clk);
    checks++;
    if (o_cdb_valid !== 1'b1 || o_cdb_owner !== 2'b00) begin
      errors++;
      $display("FAIL single_int_cdb: valid=%b owner=%b required 1/00", o_cdb_valid, o_cdb_owner);
    end
    next_cycle();
    @(negedge i_clk);
    checks++;
    if (o_cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_int_drain: valid=%b required 0", o_cdb_valid);
    end
    do_reset();
  endtask

  task automatic test_slot_conflict();
    logic [3:0] rdy [7];
    logic [3:0] exp_rd [7];
    logic [2:0] exp_cdb [7];
    rdy     = '{4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    exp_rd  = '{4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    exp_cdb = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b101, 3'b000};
    for (int c = 0; c < 7; c++) begin
      set_ready(rdy[c]);
      @(negedge i_clk);
      checks++;
      if (rd_vec() !== exp_rd[c]) begin
        errors++;
        $display("FAIL conflict_rd t+%0d: rd=%b required %b", c, rd_vec(), exp_rd[c]);
      end
      checks++;
      if (o_cdb_valid !== exp_cdb[c][2] || (exp_cdb[c][2] && o_cdb_owner !== exp_cdb[c][1:0])) begin
        errors++;
        $display("FAIL conflict_cdb t+%0d: valid/owner=%b%b required %b",
                 c, o_cdb_valid, o_cdb_owner, exp_cdb[c]);
      end
      next_cycle();
    end
    do_reset();
  endtask

  task automatic test_div_occupancy();
    logic exp_rd, exp_busy, exp_valid;
    set_ready(4'b1000);
    for (int c = 0; c < 16; c++) begin
      exp_rd    = (c == 0 || c == 7 || c == 14);
      exp_busy  = (c % 7) != 0;
      exp_valid = (c == 7 || c == 14);
      @(negedge i_clk);
      checks++;
      if (o_div_rd !== exp_rd || o_div_busy !== exp_busy) begin
        errors++;
        $display("FAIL div_occ t+%0d: div_rd=%b busy=%b required %b/%b",
                 c, o_div_rd, o_div_busy, exp_rd, exp_busy);
      end
      checks++;
      if (o_cdb_valid !== exp_valid || (exp_valid && o_cdb_owner !== 2'b11)) begin
        errors++;
        $display("FAIL div_cdb t+%0d: valid=%b owner=%b required %b/11",
                 c, o_cdb_valid, o_cdb_owner, exp_valid);
      end
      next_cycle();
    end
    set_ready(4'b0000);
    do_reset();
  endtask

  task automatic test_priority();
    logic [3:0] exp_rd [8];
    logic [2:0] exp_cdb [8];
    logic [3:0] rdy;
    exp_rd  = '{4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    exp_cdb = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b110, 3'b100, 3'b111};
    rdy = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      set_ready(rdy);
      @(negedge i_clk);
      checks++;
      if (rd_vec() !== exp_rd[c]) begin
        errors++;
        $display("FAIL priority_rd t+%0d: rd=%b required %b", c, rd_vec(), exp_rd[c]);
      end
      checks++;
      if (o_cdb_valid !== exp_cdb[c][2] || (exp_cdb[c][2] && o_cdb_owner !== exp_cdb[c][1:0])) begin
        errors++;
        $display("FAIL priority_cdb t+%0d: valid/owner=%b%b required %b",
                 c, o_cdb_valid, o_cdb_owner, exp_cdb[c]);
      end
      // Each queue holds a single entry: its ready drops once its head pops.
      rdy = rdy & ~exp_rd[c];
      next_cycle();
    end
    set_ready(4'b0000);
    do_reset();
  endtask

  task automatic test_flush();
    logic [3:0] rdy [5];
    logic       fl [5];
    logic [3:0] exp_rd [5];
    logic [2:0] exp_cdb [5];
    rdy     = '{4'b0100, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    fl      = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_rd  = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    exp_cdb = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b110};
    for (int c = 0; c < 5; c++) begin
      set_ready(rdy[c]);
      i_flush = fl[c];
      @(negedge i_clk);
      checks++;
      if (rd_vec() !== exp_rd[c]) begin
        errors++;
        $display("FAIL flush_rd t+%0d: rd=%b required %b", c, rd_vec(), exp_rd[c]);
      end
      checks++;
      if (o_cdb_valid !== exp_cdb[c][2] || (exp_cdb[c][2] && o_cdb_owner !== exp_cdb[c][1:0])) begin
        errors++;
        $display("FAIL flush_cdb t+%0d: valid/owner=%b%b required %b",
                 c, o_cdb_valid, o_cdb_owner, exp_cdb[c]);
      end
      next_cycle();
    end
    i_flush = 1'b0;
    do_reset();
  endtask

  initial begin
    i_rst   = 1'b1;
    i_flush = 1'b0;
    set_ready(4'b0000);
    test_reset();
    test_single_int();
    test_slot_conflict();
    test_div_occupancy();
    test_priority();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
